down_counter_bank: RTL and testbench
====================================

DOWN_COUNTER_BANK -- requirements
Module: down_counter_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning counter width in bits per channel (legal range 2..32).
REQ-002 The block SHALL have parameter CHANNELS, default 4, meaning number of independent counter channels (legal range 1..16).
REQ-003 The block SHALL have one clock and one reset: the clock is clk and the reset is reset, with reset asynchronous and active-low.
REQ-004 Port clk  input  1  rising-edge clock shared by all channels.
REQ-005 Port reset  input  1  asynchronous active-low reset.
REQ-006 Port en  input  CHANNELS  per-channel count enable; bit i applies to channel i.
REQ-007 Port load  input  CHANNELS  per-channel synchronous load strobe.
REQ-008 Port load_val  input  CHANNELS*WIDTH  per-channel load value; channel i uses bits [i*WIDTH +: WIDTH].
REQ-009 Port auto_reload  input  CHANNELS  per-channel mode: 1 = periodic (reload), 0 = one-shot.
REQ-010 Port count  output  CHANNELS*WIDTH  per-channel current count, same packing as load_val.
REQ-011 Port tc  output  CHANNELS  per-channel terminal-count pulse, registered.
REQ-012 Port busy  output  CHANNELS  per-channel flag: 1 while the channel is in state COUNT.

Function
REQ-013 Each channel SHALL hold a count register, a reload register (both WIDTH bits), a two-state FSM {COUNT, HALT} and a tc flop, and SHALL be independent of every other channel.
REQ-014 Load: when load[i]=1 on a rising edge, count and reload SHALL take load_val[i], the FSM SHALL enter COUNT and tc[i] SHALL be 0 next cycle, regardless of state, en[i] or count value.
REQ-015 Decrement: in COUNT with load[i]=0, en[i]=1 and count!=0, count SHALL decrement by 1.
REQ-016 Zero-reach: in COUNT with load[i]=0, en[i]=1 and count==0, tc[i] SHALL be 1 for exactly the next cycle.
REQ-017 On zero-reach with auto_reload[i]=1 (sampled on that edge), count SHALL take reload and the FSM SHALL stay in COUNT.
REQ-018 On zero-reach with auto_reload[i]=0, count SHALL hold 0 and the FSM SHALL go to HALT.
REQ-019 In HALT, count SHALL hold 0 and en[i] SHALL be ignored; only load[i] or reset SHALL leave HALT.
REQ-020 With en[i]=0 and load[i]=0, count, reload and state SHALL hold, and tc[i] SHALL be 0.
REQ-021 tc[i] SHALL be 0 on every cycle not immediately following a zero-reach edge, so back-to-back pulses occur only when reload==0 in periodic mode.
REQ-022 Loading 0 SHALL be legal: the first enabled cycle after the load is a zero-reach.
REQ-023 Arithmetic SHALL be unsigned modulo 2^WIDTH, and no decrement SHALL ever occur from 0.
REQ-024 busy[i] SHALL be combinationally equal to (state==COUNT), and count and tc SHALL come directly from flops.

Reset
REQ-025 While reset=0, every channel SHALL asynchronously set count = all ones, reload = all ones, state = COUNT and tc = 0, so busy SHALL read all ones.
REQ-026 Reset release SHALL be synchronised externally, and the first rising edge with reset=1 SHALL act per REQ-014..REQ-020.
REQ-027 Assertion of reset mid-count, or in HALT, SHALL override load and en immediately, without waiting for a clock edge.
REQ-028 With defaults after reset, en=all ones and auto_reload=all ones, each channel SHALL behave as a free-running 16-bit down counter: FFFF..0, tc, then FFFF.

Verification
REQ-029 Periodic mode: load ch0=3, auto_reload=1, en=1 -> count 3,2,1,0,3,2,...; tc[0]=1 on each cycle count shows 3 after 0; busy[0] stays 1.
REQ-030 One-shot mode: load ch1=2, auto_reload=0, en=1 -> count 2,1,0,0,...; tc[1] is a single pulse; busy[1] drops to 0; toggling en leaves count at 0; load 5 restarts with busy=1.
REQ-031 Load priority: with ch2 at count 0 and en=1, assert load=7 on the zero-reach edge -> count=7, tc[2]=0, no reload.
REQ-032 Enable hold and independence: ch3 loaded 10, en[3] toggled 1,0,1 -> count 10,9,9,8; channels 0..2 are unaffected by ch3 activity.
REQ-033 Reset mid-operation: assert reset asynchronously between edges with ch1 in HALT and ch0 at 5 -> all count=FFFF, tc=0, busy=F; after release with en=F, all counts read FFFE.
REQ-034 Wrap and width: with WIDTH=4, CHANNELS=1, reset then en=1 -> F..0 in 16 cycles, tc pulse, then F; load 0 in periodic mode -> tc high every cycle.

Source files
------------

// File: rtl/down_counter_bank.sv
// Bank of independent down counters, each with a reload register, a one-shot or
// periodic mode and a registered terminal-count pulse.
module down_counter_bank #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          en,
  input  logic [CHANNELS-1:0]          load,
  input  logic [CHANNELS*WIDTH-1:0]    load_val,
  input  logic [CHANNELS-1:0]          auto_reload,
  output logic [CHANNELS*WIDTH-1:0]    count,
  output logic [CHANNELS-1:0]          tc,
  output logic [CHANNELS-1:0]          busy
);

  typedef enum logic {
    StCount = 1'b0,
    StHalt  = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q [CHANNELS];
  logic [WIDTH-1:0] cnt_d [CHANNELS];
  logic [WIDTH-1:0] rld_q [CHANNELS];
  logic [WIDTH-1:0] rld_d [CHANNELS];
  state_e           st_q  [CHANNELS];
  state_e           st_d  [CHANNELS];
  logic [CHANNELS-1:0] tc_q, tc_d;

  always_comb begin
    tc_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      rld_d[i] = rld_q[i];
      st_d[i]  = st_q[i];
      if (load[i]) begin
        // Load wins over everything, including a simultaneous zero-reach.
        cnt_d[i] = load_val[i*WIDTH +: WIDTH];
        rld_d[i] = load_val[i*WIDTH +: WIDTH];
        st_d[i]  = StCount;
      end else if (st_q[i] == StCount && en[i]) begin
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - One;
        end else begin
          tc_d[i] = 1'b1;
          if (auto_reload[i]) begin
            cnt_d[i] = rld_q[i];
          end else begin
            st_d[i] = StHalt;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '1;
        rld_q[i] <= '1;
        st_q[i]  <= StCount;
      end
      tc_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
        rld_q[i] <= rld_d[i];
        st_q[i]  <= st_d[i];
      end
      tc_q <= tc_d;
    end
  end

  always_comb begin
    count = '0;
    busy  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      count[i*WIDTH +: WIDTH] = cnt_q[i];
      busy[i]                 = (st_q[i] == StCount);
    end
  end

  assign tc = tc_q;

endmodule

// File: tb/tb_down_counter_bank.sv
// Bench for down_counter_bank: behavioural model feeding a scoreboard queue, directed
// scenarios for each mode, async reset, and a 4-bit single-channel wrap instance.
module tb_down_counter_bank;

  localparam int W  = 16;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] en, load, auto_reload;
  logic [CH*W-1:0] load_val;
  logic [CH*W-1:0] count;
  logic [CH-1:0] tc, busy;

  logic       s_en, s_load, s_ar;
  logic [3:0] s_lv, s_cnt;
  logic       s_tc, s_busy;

  always #5 clk = ~clk;

  down_counter_bank #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .auto_reload(auto_reload), .count(count), .tc(tc), .busy(busy)
  );

  down_counter_bank #(.WIDTH(4), .CHANNELS(1)) dut_small (
    .clk(clk), .reset(reset), .en(s_en), .load(s_load), .load_val(s_lv),
    .auto_reload(s_ar), .count(s_cnt), .tc(s_tc), .busy(s_busy)
  );

  typedef struct packed {
    logic [CH*W-1:0] cnt;
    logic [CH-1:0]   tc;
    logic [CH-1:0]   busy;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [W-1:0] m_cnt [CH];
  logic [W-1:0] m_rld [CH];
  logic [CH-1:0] m_run, m_tc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = '1;
      m_rld[i] = '1;
    end
    m_run = '1;
    m_tc  = '0;
  endtask

  task automatic model_step();
    for (int i = 0; i < CH; i++) begin
      m_tc[i] = 1'b0;
      if (load[i]) begin
        m_cnt[i] = load_val[i*W +: W];
        m_rld[i] = load_val[i*W +: W];
        m_run[i] = 1'b1;
      end else if (m_run[i] && en[i]) begin
        if (m_cnt[i] == 0) begin
          m_tc[i] = 1'b1;
          if (auto_reload[i]) m_cnt[i] = m_rld[i];
          else m_run[i] = 1'b0;
        end else begin
          m_cnt[i] = m_cnt[i] - 1;
        end
      end
    end
  endtask

  // One clock: model predicts, prediction is queued, DUT output is compared after the edge.
  task automatic cycle();
    exp_t e;
    model_step();
    for (int i = 0; i < CH; i++) e.cnt[i*W +: W] = m_cnt[i];
    e.tc   = m_tc;
    e.busy = m_run;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    for (int i = 0; i < CH; i++) begin
      check_val($sformatf("sb_cnt%0d", i), 32'(count[i*W +: W]), 32'(e.cnt[i*W +: W]));
      check_val($sformatf("sb_tc%0d", i), 32'(tc[i]), 32'(e.tc[i]));
      check_val($sformatf("sb_busy%0d", i), 32'(busy[i]), 32'(e.busy[i]));
    end
  endtask

  task automatic set_lv(input int ch, input logic [W-1:0] v);
    load_val[ch*W +: W] = v;
  endtask

  function automatic logic [W-1:0] cnt_of(input int ch);
    return count[ch*W +: W];
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] p_seq [6];
    logic         p_tc  [6];
    logic [W-1:0] o_cnt [4];
    logic         o_tc  [4];
    logic         o_busy[4];
    logic         e_seq [3];
    logic [W-1:0] c_seq [3];
    p_seq = '{16'd2, 16'd1, 16'd0, 16'd3, 16'd2, 16'd1};
    p_tc  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    o_cnt = '{16'd1, 16'd0, 16'd0, 16'd0};
    o_tc  = '{1'b0, 1'b0, 1'b1, 1'b0};
    o_busy = '{1'b1, 1'b1, 1'b0, 1'b0};
    e_seq = '{1'b1, 1'b0, 1'b1};
    c_seq = '{16'd9, 16'd9, 16'd8};

    reset = 1'b0; en = '0; load = '0; auto_reload = '1; load_val = '0;
    s_en = 1'b0; s_load = 1'b0; s_ar = 1'b1; s_lv = '0;
    model_reset();
    #12;
    check_val("rst_count", 32'(count[31:0]), 32'hFFFF_FFFF);
    check_val("rst_count_hi", 32'(count[63:32]), 32'hFFFF_FFFF);
    check_val("rst_tc", 32'(tc), 32'h0);
    check_val("rst_busy", 32'(busy), 32'hF);
    reset = 1'b1;

    // Periodic channel 0
    load = 4'b0001; set_lv(0, 16'd3);
    cycle();
    check_val("per_load", 32'(cnt_of(0)), 32'd3);
    load = '0; en = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check_val("per_cnt", 32'(cnt_of(0)), 32'(p_seq[k]));
      check_val("per_tc", 32'(tc[0]), 32'(p_tc[k]));
      check_val("per_busy", 32'(busy[0]), 32'd1);
    end

    // One-shot channel 1
    auto_reload = 4'b1101; load = 4'b0010; set_lv(1, 16'd2);
    cycle();
    check_val("os_load", 32'(cnt_of(1)), 32'd2);
    load = '0; en = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check_val("os_cnt", 32'(cnt_of(1)), 32'(o_cnt[k]));
      check_val("os_tc", 32'(tc[1]), 32'(o_tc[k]));
      check_val("os_busy", 32'(busy[1]), 32'(o_busy[k]));
    end
    for (int k = 0; k < 4; k++) begin
      en[1] = ~en[1];
      cycle();
      check_val("halt_cnt", 32'(cnt_of(1)), 32'd0);
    end
    load = 4'b0010; set_lv(1, 16'd5);
    cycle();
    check_val("os_reload_cnt", 32'(cnt_of(1)), 32'd5);
    check_val("os_reload_busy", 32'(busy[1]), 32'd1);

    // Load beats zero-reach on channel 2
    load = 4'b0100; set_lv(2, 16'd1); en = 4'b0111;
    cycle();
    load = '0;
    cycle();
    check_val("lp_zero", 32'(cnt_of(2)), 32'd0);
    load = 4'b0100; set_lv(2, 16'd7);
    cycle();
    check_val("lp_cnt", 32'(cnt_of(2)), 32'd7);
    check_val("lp_tc", 32'(tc[2]), 32'd0);
    load = '0;

    // Enable hold on channel 3
    load = 4'b1000; set_lv(3, 16'd10); en[3] = 1'b0;
    cycle();
    check_val("eh_load", 32'(cnt_of(3)), 32'd10);
    load = '0;
    for (int k = 0; k < 3; k++) begin
      en[3] = e_seq[k];
      cycle();
      check_val("eh_cnt", 32'(cnt_of(3)), 32'(c_seq[k]));
    end

    // Random traffic through the scoreboard
    for (int k = 0; k < 60; k++) begin
      en = 4'($urandom);
      auto_reload = 4'($urandom);
      for (int i = 0; i < CH; i++) begin
        load[i] = ($urandom_range(0, 7) == 0);
        set_lv(i, 16'($urandom_range(0, 5)));
      end
      cycle();
    end

    // Async reset with channel 1 halted and channel 0 at 5
    en = '0; auto_reload = 4'b1101; load = 4'b0011; set_lv(0, 16'd5); set_lv(1, 16'd0);
    cycle();
    load = '0; en = 4'b0010;
    cycle();
    check_val("pre_rst_busy1", 32'(busy[1]), 32'd0);
    check_val("pre_rst_cnt0", 32'(cnt_of(0)), 32'd5);
    load = 4'b1111; en = 4'b1111;
    #3 reset = 1'b0;
    #1;
    check_val("arst_count", 32'(count[31:0]), 32'hFFFF_FFFF);
    check_val("arst_count_hi", 32'(count[63:32]), 32'hFFFF_FFFF);
    check_val("arst_tc", 32'(tc), 32'h0);
    check_val("arst_busy", 32'(busy), 32'hF);
    model_reset();
    #1 reset = 1'b1;
    load = '0; en = '1; auto_reload = '1;
    cycle();
    for (int i = 0; i < CH; i++) check_val("post_rst_cnt", 32'(cnt_of(i)), 32'hFFFE);

    // 4-bit single channel: wrap and back-to-back tc
    en = '0;
    reset = 1'b0;
    #1;
    check_val("w4_rst_cnt", 32'(s_cnt), 32'hF);
    check_val("w4_rst_busy", 32'(s_busy), 32'd1);
    #2 reset = 1'b1;
    s_en = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      check_val("w4_cnt", 32'(s_cnt), 32'(15 - k));
      check_val("w4_tc", 32'(s_tc), 32'd0);
    end
    @(posedge clk); #1;
    check_val("w4_wrap_cnt", 32'(s_cnt), 32'hF);
    check_val("w4_wrap_tc", 32'(s_tc), 32'd1);
    @(posedge clk); #1;
    check_val("w4_after_cnt", 32'(s_cnt), 32'hE);
    check_val("w4_after_tc", 32'(s_tc), 32'd0);
    s_load = 1'b1; s_lv = 4'd0;
    @(posedge clk); #1;
    check_val("w4_ld0_cnt", 32'(s_cnt), 32'd0);
    check_val("w4_ld0_tc", 32'(s_tc), 32'd0);
    s_load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_val("w4_b2b_cnt", 32'(s_cnt), 32'd0);
      check_val("w4_b2b_tc", 32'(s_tc), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
